// File: rtl/carry_chain_adder.sv
// Multi-cycle WIDTH-bit add/subtract engine: one SLICE-bit ripple step per clock,
// carry registered between slices, Start/Busy/Done handshake.
module carry_chain_slice #(
   parameter int SLICE = 32
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             ci,
   output logic [SLICE-1:0] s,
   output logic             co,
   output logic             cmsb
);
   logic [SLICE:0] sum;

   assign sum  = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};
   assign s    = sum[SLICE-1:0];
   assign co   = sum[SLICE];
   // carry into the slice MSB recovered from the sum bit
   assign cmsb = sum[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];
endmodule

module carry_chain_adder #(
   parameter int WIDTH = 128,
   parameter int SLICE = 32
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       Opsel,
   input  logic             Mode,
   output logic             Busy,
   output logic             Done,
   output logic             Error,
   output logic [WIDTH-1:0] Result,
   output logic             CarryOut,
   output logic             Overflow,
   output logic             Zero
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] opa, opb;
   logic             carry;
   logic             err_pend;

   logic [WIDTH-1:0] mux_a, mux_b;
   logic             mux_c;
   logic [SLICE-1:0] sl_a, sl_b, sl_s;
   logic             sl_co, sl_cmsb;
   logic [WIDTH-1:0] res_nxt;

   always_comb begin
      mux_a = A;
      mux_b = B;
      mux_c = 1'b0;
      case (Opsel)
         3'b010: mux_b = '0;
         3'b011: begin mux_b = ~B; mux_c = 1'b1; end
         3'b100: begin mux_b = '0; mux_c = 1'b1; end
         3'b101: mux_b = '1;
         3'b110: begin mux_a = ~A; mux_b = '0; mux_c = 1'b1; end
         3'b111: mux_a = '0;
         default: ;
      endcase
   end

   assign sl_a = opa[int'(cnt)*SLICE +: SLICE];
   assign sl_b = opb[int'(cnt)*SLICE +: SLICE];

   carry_chain_slice #(.SLICE(SLICE)) u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .ci   (carry),
      .s    (sl_s),
      .co   (sl_co),
      .cmsb (sl_cmsb)
   );

   // Result with the current slice merged in; used for the write and the Zero flag
   always_comb begin
      res_nxt = Result;
      res_nxt[int'(cnt)*SLICE +: SLICE] = sl_s;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         opa      <= '0;
         opb      <= '0;
         carry    <= 1'b0;
         err_pend <= 1'b0;
         Result   <= '0;
         CarryOut <= 1'b0;
         Overflow <= 1'b0;
         Zero     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (Start) begin
               if (Mode) begin
                  err_pend <= 1'b1;
                  state    <= S_DONE;
               end else begin
                  opa      <= mux_a;
                  opb      <= mux_b;
                  carry    <= mux_c;
                  cnt      <= '0;
                  err_pend <= 1'b0;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               Result <= res_nxt;
               carry  <= sl_co;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  CarryOut <= sl_co;
                  Overflow <= sl_cmsb ^ sl_co;
                  Zero     <= (res_nxt == '0);
                  cnt      <= '0;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               err_pend <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign Busy  = (state != S_IDLE);
   assign Done  = (state == S_DONE);
   assign Error = (state == S_DONE) && err_pend;
endmodule

// File: tb/tb_carry_chain_adder.sv
// Randomized + directed bench for carry_chain_adder against a wide-arithmetic model.
module tb_carry_chain_adder;
   localparam int W  = 128;
   localparam int NS = 4;

   logic         Clk = 1'b0;
   logic         Rst_n = 1'b0;
   logic         Start = 1'b0;
   logic [W-1:0] A = '0, B = '0;
   logic [2:0]   Opsel = 3'd0;
   logic         Mode = 1'b0;
   logic         Busy, Done, Error, CarryOut, Overflow, Zero;
   logic [W-1:0] Result;

   int nchk = 0;
   int nerr = 0;
   logic mon_en = 1'b0;

   carry_chain_adder #(.WIDTH(W), .SLICE(32)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .A(A), .B(B), .Opsel(Opsel),
      .Mode(Mode), .Busy(Busy), .Done(Done), .Error(Error), .Result(Result),
      .CarryOut(CarryOut), .Overflow(Overflow), .Zero(Zero)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [W-1:0] res;
      logic         c;
      logic         v;
      logic         z;
   } exp_t;

   // Whole-word reference: W+1 bit sum, overflow from sign bits
   function automatic exp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
      logic [W-1:0] xa, xb;
      logic         cin;
      logic [W:0]   sum;
      exp_t         e;
      xa = a; xb = b; cin = 1'b0;
      case (op)
         3'd2: xb = '0;
         3'd3: begin xb = ~b; cin = 1'b1; end
         3'd4: begin xb = '0; cin = 1'b1; end
         3'd5: xb = '1;
         3'd6: begin xa = ~a; xb = '0; cin = 1'b1; end
         3'd7: xa = '0;
         default: ;
      endcase
      sum   = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, cin};
      e.res = sum[W-1:0];
      e.c   = sum[W];
      e.v   = (e.res[W-1] ^ xa[W-1] ^ xb[W-1]) ^ sum[W];
      e.z   = (e.res == '0);
      return e;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: cycles left of busy, the visible and the pending result
   int   busy_left = 0;
   logic err_m = 1'b0;
   exp_t vis = '0, pend = '0;

   always @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         busy_left <= 0;
         err_m     <= 1'b0;
         vis       <= '0;
         pend      <= '0;
      end else if (busy_left == 0) begin
         if (Start) begin
            if (Mode) begin
               busy_left <= 1;
               err_m     <= 1'b1;
            end else begin
               busy_left <= NS + 1;
               err_m     <= 1'b0;
               pend      <= ref_op(A, B, Opsel);
            end
         end
      end else begin
         if (busy_left == 2 && !err_m) vis <= pend;
         busy_left <= busy_left - 1;
      end
   end

   always @(negedge Clk) begin
      if (mon_en) begin
         chk("busy", W'(Busy), W'(busy_left != 0));
         chk("done", W'(Done), W'(busy_left == 1));
         chk("error", W'(Error), W'(busy_left == 1 && err_m));
         chk("carryout", W'(CarryOut), W'(vis.c));
         chk("overflow", W'(Overflow), W'(vis.v));
         chk("zero", W'(Zero), W'(vis.z));
         if (busy_left <= 1) chk("result", Result, vis.res);
      end
   end

   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         lat++;
         if (Done) break;
      end
      if (!Done) lat = -1;
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         input logic md, output int lat);
      @(posedge Clk); #2;
      A = a; B = b; Opsel = op; Mode = md; Start = 1'b1;
      @(posedge Clk); #2;
      Start = 1'b0;
      A = {$urandom, $urandom, $urandom, $urandom};
      B = {$urandom, $urandom, $urandom, $urandom};
      Opsel = 3'($urandom);
      wait_done(lat);
   endtask

   task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op, input logic [W-1:0] eres,
                           input logic ec, input logic ev, input logic ez);
      int   lat;
      exp_t m;
      m = ref_op(a, b, op);
      chk({name, "_model_res"}, m.res, eres);
      chk({name, "_model_flags"}, W'({m.c, m.v, m.z}), W'({ec, ev, ez}));
      run_op(a, b, op, 1'b0, lat);
      chk({name, "_latency"}, W'(lat), W'(NS + 1));
      chk({name, "_res"}, Result, eres);
      chk({name, "_c"}, W'(CarryOut), W'(ec));
      chk({name, "_v"}, W'(Overflow), W'(ev));
      chk({name, "_z"}, W'(Zero), W'(ez));
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return {1'b0, {(W-1){1'b1}}};
         3: return {1'b1, {(W-1){1'b0}}};
         4: return W'($urandom);
         default: return {$urandom, $urandom, $urandom, $urandom};
      endcase
   endfunction

   initial begin
      int lat;
      int seen;
      logic [W-1:0] ones, maxpos, minneg;
      ones   = '1;
      maxpos = {1'b0, {(W-1){1'b1}}};
      minneg = {1'b1, {(W-1){1'b0}}};

      repeat (2) @(posedge Clk);
      mon_en = 1'b1;
      @(negedge Clk);
      chk("reset_result", Result, '0);
      chk("reset_status", W'({Busy, Done, Error, CarryOut, Overflow, Zero}), '0);
      @(posedge Clk); #2 Rst_n = 1'b1;

      directed("add_wrap", W'(1), ones, 3'd0, '0, 1'b1, 1'b0, 1'b1);
      directed("sub_5_7", W'(5), W'(7), 3'd3, ones - W'(1), 1'b0, 1'b0, 1'b0);
      directed("add_ovf", maxpos, W'(1), 3'd1, minneg, 1'b0, 1'b1, 1'b0);
      directed("neg_0", '0, W'(123), 3'd6, '0, 1'b1, 1'b0, 1'b1);
      directed("inc_slice", W'(32'hFFFF_FFFF), '0, 3'd4, W'(1) << 32, 1'b0, 1'b0, 1'b0);
      directed("dec_0", '0, W'(9), 3'd5, ones, 1'b0, 1'b0, 1'b0);

      // Start during RUN with new operands must be ignored
      @(posedge Clk); #2;
      A = W'(3); B = W'(4); Opsel = 3'd0; Mode = 1'b0; Start = 1'b1;
      @(posedge Clk); #2 Start = 1'b0;
      @(posedge Clk); #2 A = W'(100); B = W'(100); Start = 1'b1;
      @(posedge Clk); #2 Start = 1'b0;
      wait_done(lat);
      chk("ignore_start_done", W'(lat > 0), W'(1));
      chk("ignore_start_res", Result, W'(7));

      // Reset in the middle of RUN: everything clears, no Done
      @(posedge Clk); #2;
      A = W'(9); Opsel = 3'd4; Start = 1'b1;
      @(posedge Clk); #2 Start = 1'b0;
      @(posedge Clk); #2 Rst_n = 1'b0;
      @(negedge Clk);
      chk("midrun_reset_result", Result, '0);
      chk("midrun_reset_busy", W'(Busy), '0);
      @(posedge Clk); #2 Rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge Clk);
         if (Done) seen++;
      end
      chk("no_done_after_reset", W'(seen), '0);

      // Logic-mode request: Error with Done one cycle later, Result untouched
      run_op(W'(10), W'(20), 3'd0, 1'b0, lat);
      chk("pre_err_res", Result, W'(30));
      run_op(ones, ones, 3'd0, 1'b1, lat);
      chk("err_latency", W'(lat), W'(1));
      chk("err_flag", W'(Error), W'(1));
      chk("err_res_kept", Result, W'(30));

      for (int i = 0; i < 60; i++) begin
         run_op(pick(), pick(), 3'($urandom), ($urandom_range(0, 9) == 0), lat);
         if (lat < 0) chk("rand_timeout", W'(0), W'(1));
      end

      repeat (3) @(negedge Clk);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
